// File: rtl/pulse_meas_pkg.sv
// Shared state encoding, default timing constants and tolerance helper for pulse_meas.
package pulse_meas_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOW1 = 2'd1;
  localparam state_t HIGH = 2'd2;
  localparam state_t LOW2 = 2'd3;

  localparam int CNT_W         = 16;
  localparam int DEF_EXP_LOW1  = 200;
  localparam int DEF_EXP_HIGH  = 100;
  localparam int DEF_EXP_LOW2  = 200;
  localparam int DEF_TOL       = 4;
  localparam int DEF_TIMEOUT   = 1023;

  // True when a measured length is within +/- tol of its expected value.
  function automatic logic within_tol(input logic [CNT_W-1:0] meas,
                                      input int expected, input int tol);
    int diff;
    diff = int'(meas) - expected;
    return (diff <= tol) && (diff >= -tol);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; flops reset to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pulse_meas.sv
// Measures a low/high/low framed pulse on wave_in and strobes done or err_timeout per frame.
// Optional tolerance checking of the three segments is enabled by PULSE_MEAS_TOL_CHECK_EN.
module pulse_meas
  import pulse_meas_pkg::*;
#(
  parameter int EXP_LOW1 = DEF_EXP_LOW1,
  parameter int EXP_HIGH = DEF_EXP_HIGH,
  parameter int EXP_LOW2 = DEF_EXP_LOW2,
  parameter int TOL      = DEF_TOL,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             wave_in,
  output logic [CNT_W-1:0] meas_low1,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_low2,
  output logic             done,
  output logic             pass,
  output logic             err_timeout
);

  if (TIMEOUT < 1 || TIMEOUT >= 65535) begin : g_bad_timeout
    $error("pulse_meas: TIMEOUT must lie in 1..65534 so cnt cannot wrap");
  end

  if (EXP_LOW1 < 1 || EXP_HIGH < 1 || EXP_LOW2 < 1 || TOL < 0) begin : g_bad_expect
    $error("pulse_meas: EXP_* must be positive and TOL non-negative");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic             ws;
  logic             ws_d;
  logic [1:0]       settle;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             fall;
  logic             seg_hold;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk_in),
    .rst (rst),
    .d   (wave_in),
    .q   (ws)
  );

  // The synchronizer comes out of reset at 1; if the line is really low, that
  // reset value would look like a falling edge. Edges are ignored until the
  // pipeline has been refilled from the live input.
  assign fall     = ws_d && !ws && (settle == 2'd3);
  assign seg_hold = (state == HIGH) ? ws : !ws;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ws_d        <= 1'b1;
      settle      <= 2'd0;
      meas_low1   <= '0;
      meas_high   <= '0;
      meas_low2   <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      ws_d        <= ws;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      if (settle != 2'd3) settle <= settle + 2'd1;

      if (state == IDLE) begin
        if (fall) begin
          state <= LOW1;
          cnt   <= CNT_W'(1);
        end else begin
          cnt <= '0;
        end
      end else if (seg_hold) begin
        // Level still held: abort once the segment would exceed TIMEOUT.
        if (cnt >= CNT_MAX) begin
          err_timeout <= 1'b1;
          state       <= IDLE;
          cnt         <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= CNT_W'(1);
        case (state)
          LOW1: begin
            meas_low1 <= cnt;
            state     <= HIGH;
          end
          HIGH: begin
            meas_high <= cnt;
            state     <= LOW2;
          end
          default: begin
            meas_low2 <= cnt;
            done      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
          end
        endcase
      end
    end
  end

`ifdef PULSE_MEAS_TOL_CHECK_EN
  logic frame_end;
  logic frame_ok;

  // Low2 is judged from cnt since meas_low2 only updates on this same edge.
  assign frame_end = (state == LOW2) && ws;
  assign frame_ok  = within_tol(meas_low1, EXP_LOW1, TOL) &&
                     within_tol(meas_high, EXP_HIGH, TOL) &&
                     within_tol(cnt, EXP_LOW2, TOL);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      pass <= 1'b0;
    end else begin
      pass <= frame_end && frame_ok;
    end
  end
`else
  assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_meas.sv
// Self-checking bench for pulse_meas: vector table, hand-written corner sequences and random frames.
// Define PULSE_MEAS_TOL_CHECK_EN for both bench and RTL to expect tolerance results on pass.
module tb_pulse_meas;
  import pulse_meas_pkg::*;

  localparam int EXP_L1 = 200;
  localparam int EXP_H  = 100;
  localparam int EXP_L2 = 200;
  localparam int TOL_V  = 4;
  localparam int TMO    = 1023;
  // wave_in change -> 2 synchronizer flops -> registered strobe
  localparam int LAT    = 3;

  logic        clk_in  = 1'b0;
  logic        rst     = 1'b0;
  logic        wave_in = 1'b1;
  logic [15:0] meas_low1, meas_high, meas_low2;
  logic        done, pass, err_timeout;

  pulse_meas #(
    .EXP_LOW1 (EXP_L1),
    .EXP_HIGH (EXP_H),
    .EXP_LOW2 (EXP_L2),
    .TOL      (TOL_V),
    .TIMEOUT  (TMO)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .wave_in     (wave_in),
    .meas_low1   (meas_low1),
    .meas_high   (meas_high),
    .meas_low2   (meas_low2),
    .done        (done),
    .pass        (pass),
    .err_timeout (err_timeout)
  );

  always #50 clk_in = ~clk_in;

  typedef struct {
    int l1, h, l2;
    int m1, m2, m3;
    bit pass_on;
  } vec_t;

  vec_t tbl[9];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt, err_cnt, both_cnt, stray_pass, done_cyc, err_cyc;
  logic [15:0] cap_l1, cap_h, cap_l2;
  logic        cap_pass;
  logic [15:0] exp_l1 = '0, exp_h = '0, exp_l2 = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, then drive the next wave level.
  task automatic step(input logic w);
    @(negedge clk_in);
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      cap_l1   = meas_low1;
      cap_h    = meas_high;
      cap_l2   = meas_low2;
      cap_pass = pass;
    end
    if (err_timeout) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (done && err_timeout) both_cnt++;
    if (pass && !done) stray_pass++;
    wave_in = w;
  endtask

  task automatic drive_level(input logic w, input int n);
    for (int i = 0; i < n; i++) step(w);
  endtask

  task automatic clear_events();
    done_cnt = 0; err_cnt = 0; both_cnt = 0; stray_pass = 0;
    done_cyc = -1; err_cyc = -1;
  endtask

  function automatic bit in_tol(input int v, input int e);
    return ((v > e) ? v - e : e - v) <= TOL_V;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check($sformatf("%s meas_low1", tag), meas_low1, 0);
    check($sformatf("%s meas_high", tag), meas_high, 0);
    check($sformatf("%s meas_low2", tag), meas_low2, 0);
    check($sformatf("%s done", tag), done, 0);
    check($sformatf("%s pass", tag), pass, 0);
    check($sformatf("%s err_timeout", tag), err_timeout, 0);
  endtask

  task automatic check_meas_hold(input string tag);
    check($sformatf("%s hold meas_low1", tag), meas_low1, exp_l1);
    check($sformatf("%s hold meas_high", tag), meas_high, exp_h);
    check($sformatf("%s hold meas_low2", tag), meas_low2, exp_l2);
  endtask

  // Complete frame with every segment within TIMEOUT; wave is idle high beforehand.
  task automatic run_frame(input int l1, input int h, input int l2, input int gap,
                           input int m1, input int m2, input int m3,
                           input bit pass_on, input string tag);
    int rise_cyc;
    bit exp_pass;
    clear_events();
    drive_level(1'b0, l1);
    drive_level(1'b1, h);
    drive_level(1'b0, l2);
    rise_cyc = cyc + 1;
    drive_level(1'b1, gap);
    exp_l1 = 16'(m1);
    exp_h  = 16'(m2);
    exp_l2 = 16'(m3);
`ifdef PULSE_MEAS_TOL_CHECK_EN
    exp_pass = pass_on;
`else
    exp_pass = 1'b0;
`endif
    check($sformatf("%s done count", tag), done_cnt, 1);
    check($sformatf("%s err count", tag), err_cnt, 0);
    check($sformatf("%s done latency", tag), done_cyc - rise_cyc, LAT);
    check($sformatf("%s meas_low1 at done", tag), cap_l1, exp_l1);
    check($sformatf("%s meas_high at done", tag), cap_h, exp_h);
    check($sformatf("%s meas_low2 at done", tag), cap_l2, exp_l2);
    check($sformatf("%s pass at done", tag), cap_pass, exp_pass);
    check($sformatf("%s pass outside done", tag), stray_pass, 0);
    check_meas_hold(tag);
  endtask

  initial begin
    int f_cyc;
    int l1, h, l2;

    tbl[0] = '{200, 100, 200, 200, 100, 200, 1'b1};
    tbl[1] = '{200, 110, 200, 200, 110, 200, 1'b0};
    tbl[2] = '{203,  97, 196, 203,  97, 196, 1'b1};
    tbl[3] = '{204,  96, 204, 204,  96, 204, 1'b1};
    tbl[4] = '{205, 100, 200, 205, 100, 200, 1'b0};
    tbl[5] = '{200, 100, 195, 200, 100, 195, 1'b0};
    tbl[6] = '{196, 104, 196, 196, 104, 196, 1'b1};
    tbl[7] = '{200,  95, 200, 200,  95, 200, 1'b0};
    tbl[8] = '{  1,   1,   1,   1,   1,   1, 1'b0};

    // Reset state
    clear_events();
    drive_level(1'b1, 4);
    check_outputs_zero("reset");
    rst = 1'b1;
    drive_level(1'b1, 10);

    for (int i = 0; i < 9; i++)
      run_frame(tbl[i].l1, tbl[i].h, tbl[i].l2, 10, tbl[i].m1, tbl[i].m2, tbl[i].m3,
                tbl[i].pass_on, $sformatf("vec%0d", i));

    // Line held low far past TIMEOUT: one abort, no restart on the level
    clear_events();
    f_cyc = cyc + 1;
    drive_level(1'b0, 2000);
    drive_level(1'b1, 20);
    check("timeout err count", err_cnt, 1);
    check("timeout done count", done_cnt, 0);
    check("timeout err cycle", err_cyc - f_cyc, TMO + LAT);
    check("timeout done/err overlap", both_cnt, 0);
    check_meas_hold("timeout");
    run_frame(200, 100, 200, 10, 200, 100, 200, 1'b1, "after timeout");

    // One-cycle glitch: low1 of 1, then the high segment times out
    clear_events();
    f_cyc = cyc + 1;
    drive_level(1'b0, 1);
    drive_level(1'b1, TMO + 20);
    exp_l1 = 16'd1;
    check("glitch err count", err_cnt, 1);
    check("glitch done count", done_cnt, 0);
    check("glitch err cycle", err_cyc - (f_cyc + 1), TMO + LAT);
    check_meas_hold("glitch");
    run_frame(200, 100, 200, 10, 200, 100, 200, 1'b1, "after glitch");

    // Reset 50 cycles into low2, released while the line is still low
    clear_events();
    drive_level(1'b0, 200);
    drive_level(1'b1, 100);
    drive_level(1'b0, 50);
    rst = 1'b0;
    #1;
    check_outputs_zero("mid-frame reset");
    exp_l1 = '0; exp_h = '0; exp_l2 = '0;
    drive_level(1'b0, 3);
    rst = 1'b1;
    drive_level(1'b0, 97);
    drive_level(1'b1, 20);
    check("reset abort done count", done_cnt, 0);
    check("reset abort err count", err_cnt, 0);
    check_meas_hold("reset abort");
    run_frame(200, 100, 200, 10, 200, 100, 200, 1'b1, "after reset");

    // Random frames against the segment-length model
    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        l1 = EXP_L1 + int'($urandom_range(0, 2*TOL_V + 4)) - (TOL_V + 2);
        h  = EXP_H  + int'($urandom_range(0, 2*TOL_V + 4)) - (TOL_V + 2);
        l2 = EXP_L2 + int'($urandom_range(0, 2*TOL_V + 4)) - (TOL_V + 2);
      end else begin
        l1 = int'($urandom_range(1, 350));
        h  = int'($urandom_range(1, 350));
        l2 = int'($urandom_range(1, 350));
      end
      run_frame(l1, h, l2, int'($urandom_range(4, 12)), l1, h, l2,
                in_tol(l1, EXP_L1) && in_tol(h, EXP_H) && in_tol(l2, EXP_L2),
                $sformatf("rand%0d(%0d/%0d/%0d)", k, l1, h, l2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
